// File: rtl/s1_pkg.sv
// Shared constants for the s1 select-mux pipeline.
package s1_pkg;

  // Mux select encoding: {a1|b1, a0&s0_en}.
  localparam logic [1:0] SEL_00 = 2'b00;
  localparam logic [1:0] SEL_01 = 2'b01;
  localparam logic [1:0] SEL_10 = 2'b10;
  localparam logic [1:0] SEL_11 = 2'b11;

  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 8;

endpackage

// File: rtl/s1_pipe_stage.sv
// One pipeline slot: WIDTH-bit data register plus valid bit.
// Loads (or drains to empty) whenever the top grants it a load slot.
module s1_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only captured for a real upstream item; stale data is masked by valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/s1_pipe.sv
// Select-driven 4:1 mux feeding a DEPTH-stage ready/valid pipeline
// with an occupancy counter.
module s1_pipe
  import s1_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d00,
  input  logic [WIDTH-1:0] d01,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic             a0,
  input  logic             s0_en,
  input  logic             a1,
  input  logic             b1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("s1_pipe: DEPTH outside legal range");
  end

  logic [1:0]             sel_c;
  logic [WIDTH-1:0]       mux_c;
  logic [DEPTH:0]         vld;
  logic [DEPTH:0][WIDTH-1:0] dat;
  logic [DEPTH:0]         rdy;
  logic                   in_fire;
  logic                   out_fire;
  logic [OCC_W-1:0]       occ;

  // Operand select ahead of stage 0.
  always_comb begin
    sel_c = {a1 | b1, a0 & s0_en};
    mux_c = d00;
    case (sel_c)
      SEL_00: mux_c = d00;
      SEL_01: mux_c = d01;
      SEL_10: mux_c = d10;
      SEL_11: mux_c = d11;
      default: mux_c = d00;
    endcase
  end

  assign vld[0] = in_valid;
  assign dat[0] = mux_c;

  // Stage k may load if empty or its successor frees it; successor of the head is out_ready.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy[k] = ~vld[k+1] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    s1_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .clr      (clr),
      .load     (rdy[k]),
      .up_valid (vld[k]),
      .up_data  (dat[k]),
      .valid    (vld[k+1]),
      .data     (dat[k+1])
    );
  end

  // Handshakes are suppressed while clr is asserted.
  assign in_ready  = rdy[0] & ~clr;
  assign out_valid = vld[DEPTH] & ~clr;
  assign out       = dat[DEPTH];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      occ <= '0;
    end else if (in_fire && !out_fire && occ != OCC_W'(DEPTH)) begin
      occ <= occ + OCC_W'(1);
    end else if (out_fire && !in_fire && occ != '0) begin
      occ <= occ - OCC_W'(1);
    end
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_s1_pipe.sv
// Directed and streaming checks of s1_pipe at DEPTH=2, plus DEPTH=1/8 scoreboards.
module tb_s1_pipe;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr;
  logic [W-1:0] d00, d01, d10, d11;
  logic         a0, s0_en, a1, b1;
  logic         in_valid, out_ready;

  logic rdy2, ov2; logic [W-1:0] o2; logic [1:0] occ2;
  logic rdy1, ov1; logic [W-1:0] o1; logic [0:0] occ1;
  logic rdy8, ov8; logic [W-1:0] o8; logic [3:0] occ8;

  s1_pipe #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .clr(clr), .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a0(a0), .s0_en(s0_en), .a1(a1), .b1(b1), .in_valid(in_valid),
    .in_ready(rdy2), .out(o2), .out_valid(ov2), .out_ready(out_ready),
    .occupancy(occ2));

  s1_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .clr(clr), .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a0(a0), .s0_en(s0_en), .a1(a1), .b1(b1), .in_valid(in_valid),
    .in_ready(rdy1), .out(o1), .out_valid(ov1), .out_ready(out_ready),
    .occupancy(occ1));

  s1_pipe #(.WIDTH(W), .DEPTH(8)) dut8 (
    .clk(clk), .clr(clr), .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a0(a0), .s0_en(s0_en), .a1(a1), .b1(b1), .in_valid(in_valid),
    .in_ready(rdy8), .out(o8), .out_valid(ov8), .out_ready(out_ready),
    .occupancy(occ8));

  logic         ov_v  [3];
  logic         rdy_v [3];
  logic [W-1:0] o_v   [3];
  int           occ_v [3];
  assign ov_v[0] = ov2;  assign rdy_v[0] = rdy2; assign o_v[0] = o2; assign occ_v[0] = int'(occ2);
  assign ov_v[1] = ov1;  assign rdy_v[1] = rdy1; assign o_v[1] = o1; assign occ_v[1] = int'(occ1);
  assign ov_v[2] = ov8;  assign rdy_v[2] = rdy8; assign o_v[2] = o8; assign occ_v[2] = int'(occ8);

  int checks;
  int failures;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [3:0] v);
    {a0, s0_en, a1, b1} = v;
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (rdy2 !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during_clr: got %0b expected 0", rdy2); end
    step(); step();
    checks++;
    if (occ2 !== 2'd0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", occ2); end
    checks++;
    if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", ov2); end
    checks++;
    if (o2 !== 8'h00) begin failures++; $display("FAIL reset_out: got %0h expected 0", o2); end
    in_valid = 1'b0;
    clr = 1'b0;
    #1;
    checks++;
    if (rdy2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after_clr: got %0b expected 1", rdy2); end
  endtask

  task automatic test_mux();
    logic [3:0]   vec [4];
    logic [W-1:0] exp [4];
    vec = '{4'b1100, 4'b1001, 4'b1110, 4'b0100};
    exp = '{8'h22, 8'h33, 8'h44, 8'h11};
    d00 = 8'h11; d01 = 8'h22; d10 = 8'h33; d11 = 8'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sel(vec[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      set_sel(4'b0000);
      #1;
      checks++;
      if (ov2 !== 1'b0) begin failures++; $display("FAIL mux%0d_early_valid: got %0b expected 0", i, ov2); end
      step();
      checks++;
      if (ov2 !== 1'b1 || o2 !== exp[i]) begin
        failures++; $display("FAIL mux%0d_result: got valid=%0b out=%0h expected valid=1 out=%0h", i, ov2, o2, exp[i]);
      end
      step();
      checks++;
      if (occ2 !== 2'd0 || ov2 !== 1'b0) begin
        failures++; $display("FAIL mux%0d_drain: got occ=%0d valid=%0b expected occ=0 valid=0", i, occ2, ov2);
      end
    end
  endtask

  task automatic test_stall_and_simultaneous();
    logic [W-1:0] nxt;
    logic [3:0]   exp_rdy;
    int           got;
    exp_rdy = 4'b0011;
    set_sel(4'b0000);
    out_ready = 1'b0;
    nxt = 8'd1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; d00 = nxt;
      #1;
      checks++;
      if (rdy2 !== exp_rdy[c]) begin failures++; $display("FAIL stall_in_ready_c%0d: got %0b expected %0b", c, rdy2, exp_rdy[c]); end
      if (rdy2 === 1'b1) nxt++;
      step();
      if (c >= 1) begin
        checks++;
        if (ov2 !== 1'b1 || o2 !== 8'd1) begin
          failures++; $display("FAIL stall_head_hold_c%0d: got valid=%0b out=%0h expected valid=1 out=1", c, ov2, o2);
        end
      end
    end
    checks++;
    if (occ2 !== 2'd2) begin failures++; $display("FAIL stall_full_occupancy: got %0d expected 2", occ2); end

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      in_valid = (nxt <= 8'd4); d00 = nxt;
      #1;
      if (c == 0) begin
        checks++;
        if (rdy2 !== 1'b1) begin failures++; $display("FAIL simul_in_ready: got %0b expected 1", rdy2); end
      end
      if (ov2 === 1'b1) begin
        checks++;
        if (o2 !== 8'(got + 1)) begin failures++; $display("FAIL drain_order_%0d: got %0h expected %0h", got, o2, 8'(got + 1)); end
        got++;
      end
      if (in_valid && rdy2 === 1'b1) nxt++;
      step();
      if (c == 0) begin
        checks++;
        if (occ2 !== 2'd2) begin failures++; $display("FAIL simul_occupancy: got %0d expected 2", occ2); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin failures++; $display("FAIL drain_count: got %0d expected 4", got); end
    checks++;
    if (occ2 !== 2'd0) begin failures++; $display("FAIL drain_occupancy: got %0d expected 0", occ2); end
  endtask

  task automatic test_clr_in_flight();
    set_sel(4'b0000);
    out_ready = 1'b0;
    in_valid = 1'b1; d00 = 8'h05; step();
    d00 = 8'h06; step();
    in_valid = 1'b0;
    checks++;
    if (occ2 !== 2'd2) begin failures++; $display("FAIL clr_prefill_occupancy: got %0d expected 2", occ2); end
    clr = 1'b1;
    #1;
    checks++;
    if (ov2 !== 1'b0 || rdy2 !== 1'b0) begin
      failures++; $display("FAIL clr_gating: got valid=%0b ready=%0b expected 0 0", ov2, rdy2);
    end
    step();
    checks++;
    if (occ2 !== 2'd0 || ov2 !== 1'b0 || o2 !== 8'h00) begin
      failures++; $display("FAIL clr_flush: got occ=%0d valid=%0b out=%0h expected 0 0 0", occ2, ov2, o2);
    end
    clr = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; d00 = 8'h77;
    #1;
    checks++;
    if (rdy2 !== 1'b1) begin failures++; $display("FAIL clr_first_accept: got %0b expected 1", rdy2); end
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (ov2 !== 1'b1 || o2 !== 8'h77) begin
      failures++; $display("FAIL clr_first_result: got valid=%0b out=%0h expected valid=1 out=77", ov2, o2);
    end
    step();
    checks++;
    if (occ2 !== 2'd0) begin failures++; $display("FAIL clr_post_drain: got %0d expected 0", occ2); end
  endtask

  task automatic test_stream();
    logic [W-1:0] mem [3][16];
    int wp [3];
    int rp [3];
    int dep [3];
    dep = '{2, 1, 8};
    wp = '{0, 0, 0};
    rp = '{0, 0, 0};
    set_sel(4'b0000);
    in_valid = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    for (int c = 0; c < 700; c++) begin
      in_valid  = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d00       = 8'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (occ_v[i] !== (wp[i] - rp[i]) || occ_v[i] > dep[i]) begin
          failures++; $display("FAIL stream_occ_d%0d_c%0d: got %0d expected %0d", dep[i], c, occ_v[i], wp[i] - rp[i]);
        end
        if (ov_v[i] === 1'b1 && out_ready) begin
          checks++;
          if (wp[i] == rp[i]) begin
            failures++; $display("FAIL stream_spurious_d%0d_c%0d: got out=%0h expected no valid output", dep[i], c, o_v[i]);
          end else begin
            if (o_v[i] !== mem[i][rp[i] % 16]) begin
              failures++; $display("FAIL stream_data_d%0d_c%0d: got %0h expected %0h", dep[i], c, o_v[i], mem[i][rp[i] % 16]);
            end
            rp[i]++;
          end
        end
        if (in_valid && rdy_v[i] === 1'b1) begin
          mem[i][wp[i] % 16] = d00;
          wp[i]++;
        end
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rp[i] !== wp[i] || wp[i] < 50) begin
        failures++; $display("FAIL stream_count_d%0d: got emitted=%0d expected accepted=%0d", dep[i], rp[i], wp[i]);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    d00 = '0; d01 = '0; d10 = '0; d11 = '0;
    a0 = 1'b0; s0_en = 1'b0; a1 = 1'b0; b1 = 1'b0;
    test_reset();
    test_mux();
    test_stall_and_simultaneous();
    test_clr_in_flight();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s1_pipe.md
S1_PIPE -- requirements
Module: s1_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data operand and of the result.
REQ-002 Parameter DEPTH, default 2, legal range 1..8: number of registered pipeline stages.
REQ-003 Parameter OCC_W, default $clog2(DEPTH+1): width of the occupancy output.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 clr  input  1  synchronous, active-high reset.
REQ-006 d00, d01, d10, d11  input  WIDTH each  mux data operands.
REQ-007 a0, s0_en  input  1 each  select term 0 sources.
REQ-008 a1, b1  input  1 each  select term 1 sources.
REQ-009 in_valid  input  1  upstream presents operands and select terms.
REQ-010 in_ready  output  1  block accepts the input this cycle.
REQ-011 out  output  WIDTH  result at pipeline head.
REQ-012 out_valid  output  1  out holds a valid result.
REQ-013 out_ready  input  1  downstream consumes out this cycle.
REQ-014 occupancy  output  OCC_W  count of valid stages.

Function
REQ-015 Select SHALL be sel[0] = a0 & s0_en and sel[1] = a1 | b1, sampled only on an accepted input.
REQ-016 Mux SHALL pick d00/d01/d10/d11 for sel = 00/01/10/11, combinationally, ahead of stage 0.
REQ-017 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-018 Stage k SHALL be able to load when it is empty or stage k+1 loads or unloads this cycle; the last stage's successor is out_ready.
REQ-019 in_ready SHALL equal the stage-0 load condition; no combinational path from in_valid to in_ready.
REQ-020 Latency: with out_ready held high, a result accepted at edge N SHALL appear with out_valid high after edge N+DEPTH-1 (visible from edge N for DEPTH=1).
REQ-021 Throughput: one transfer per cycle SHALL be sustained when out_ready is held high.
REQ-022 Stall: with out_ready low, stages SHALL fill head-first; out and out_valid SHALL hold stable until consumed.
REQ-023 Full: when all DEPTH stages are valid and out_ready is low, in_ready SHALL be 0 and no data SHALL be lost or overwritten.
REQ-024 Simultaneous: full pipeline with out_ready high SHALL accept a new input in the same cycle; occupancy SHALL stay DEPTH.
REQ-025 Occupancy SHALL increment on input-only transfer, decrement on output-only, and be unchanged on both or neither; it SHALL never exceed DEPTH or wrap below 0.
REQ-026 Results SHALL leave in acceptance order; invalid stage contents SHALL never drive out_valid.

Reset
REQ-027 clr high at a rising edge SHALL clear all stage valid bits, occupancy to 0, and out to 0, overriding any transfer in the same cycle.
REQ-028 While clr is high, in_ready SHALL be 0 and out_valid 0; data in flight SHALL be discarded.
REQ-029 The first input SHALL be accepted in the first cycle after clr deasserts.

Structure
REQ-030 Shared package s1_pkg SHALL hold the select encoding constants (SEL_00..SEL_11) and the DEPTH legal-range limits.
REQ-031 One sub-module, s1_pipe_stage (WIDTH-bit data register + valid bit + load/unload handshake), SHALL be instantiated DEPTH times; the mux and occupancy counter SHALL live in the top.

Verification
REQ-032 WIDTH=8, DEPTH=2, out_ready=1; d00..d11=11,22,33,44, a0=1,s0_en=1,a1=0,b1=0 -> out=0x22 with out_valid after 2 edges.
REQ-033 Same operands, a0=1,s0_en=0,a1=0,b1=1 -> sel=10, out=0x33; a1=1,b1=0,a0=1,s0_en=1 -> out=0x44.
REQ-034 out_ready=0, in_valid=1 for 4 cycles, values 1,2,3,4 -> in_ready drops after 2 accepts, occupancy=2, out=1 held; out_ready=1 -> 1,2 then 3,4 emitted in order.
REQ-035 Full pipeline, out_ready=1 and in_valid=1 in same cycle -> one in, one out, occupancy stays 2.
REQ-036 clr asserted while occupancy=2 -> next edge occupancy=0, out_valid=0, out=0; first post-clr input emerges unchanged.
REQ-037 DEPTH=1 and DEPTH=8 builds with streaming random data and random out_ready -> scoreboard order and count match; occupancy within 0..DEPTH.
